// File: rtl/mem_wb_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and data memory (slave).
interface mem_wb_stage_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ready, rdata);
  modport slave  (input req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB pipeline register: issues data-memory accesses, stalls upstream
// while one is outstanding, and aborts accesses that hang longer than TIMEOUT cycles.
module mem_wb_stage #(
  parameter int DATA_W  = 32,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_read_data2,
  input  logic [RD_W-1:0]   ex_rd_addr,
  mem_wb_stage_if.master    dmem,
  output logic              stall,
  output logic              err,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [DATA_W-1:0] wb_mem_data,
  output logic [RD_W-1:0]   wb_rd_addr
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic              req_c, we_c, timeout_hit;
  logic [DATA_W-1:0] addr_c, wdata_c;

  logic              hold_we, hold_reg_write, hold_mem_to_reg;
  logic [DATA_W-1:0] hold_addr, hold_wdata;
  logic [RD_W-1:0]   hold_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // In WAIT the bus is driven purely from the hold registers so upstream inputs cannot disturb it.
  always_comb begin
    state_next  = state;
    req_c       = 1'b0;
    we_c        = 1'b0;
    addr_c      = '0;
    wdata_c     = '0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        req_c   = ex_mem_read | ex_mem_write;
        we_c    = ex_mem_write;
        addr_c  = ex_alu_result;
        wdata_c = ex_read_data2;
        if (req_c && !dmem.ready) state_next = WAIT;
      end
      WAIT: begin
        req_c       = 1'b1;
        we_c        = hold_we;
        addr_c      = hold_addr;
        wdata_c     = hold_wdata;
        timeout_hit = (TIMEOUT > 0) && (cnt == CNT_LAST) && !dmem.ready;
        if (dmem.ready || timeout_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign dmem.req   = req_c & rst_n;
  assign dmem.we    = we_c;
  assign dmem.addr  = addr_c;
  assign dmem.wdata = wdata_c;
  assign stall      = rst_n & req_c & ~dmem.ready & ~timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == WAIT && state_next == WAIT) begin
      if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_we         <= 1'b0;
      hold_reg_write  <= 1'b0;
      hold_mem_to_reg <= 1'b0;
      hold_addr       <= '0;
      hold_wdata      <= '0;
      hold_rd         <= '0;
    end else if (state == IDLE && req_c && !dmem.ready) begin
      hold_we         <= ex_mem_write;
      hold_reg_write  <= ex_reg_write;
      hold_mem_to_reg <= ex_mem_to_reg;
      hold_addr       <= ex_alu_result;
      hold_wdata      <= ex_read_data2;
      hold_rd         <= ex_rd_addr;
    end
  end

  // A read+write combination counts as a store, so it never returns load data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err           <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_alu_result <= '0;
      wb_mem_data   <= '0;
      wb_rd_addr    <= '0;
    end else begin
      err <= 1'b0;
      if (state == IDLE && (!req_c || dmem.ready)) begin
        wb_reg_write  <= ex_reg_write;
        wb_mem_to_reg <= ex_mem_to_reg;
        wb_alu_result <= ex_alu_result;
        wb_rd_addr    <= ex_rd_addr;
        wb_mem_data   <= (req_c && !ex_mem_write) ? dmem.rdata : '0;
      end else if (state == WAIT && dmem.ready) begin
        wb_reg_write  <= hold_reg_write;
        wb_mem_to_reg <= hold_mem_to_reg;
        wb_alu_result <= hold_addr;
        wb_rd_addr    <= hold_rd;
        wb_mem_data   <= hold_we ? '0 : dmem.rdata;
      end else begin
        wb_reg_write  <= 1'b0;
        wb_mem_to_reg <= 1'b0;
        wb_mem_data   <= '0;
        err           <= timeout_hit;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios followed by random transactions
// compared against a transaction-level model with its own view of memory contents.
module tb_mem_wb_stage;

  localparam int DATA_W  = 32;
  localparam int RD_W    = 5;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
  logic [DATA_W-1:0] ex_alu_result, ex_read_data2;
  logic [RD_W-1:0]   ex_rd_addr;
  logic              stall, err, wb_reg_write, wb_mem_to_reg;
  logic [DATA_W-1:0] wb_alu_result, wb_mem_data;
  logic [RD_W-1:0]   wb_rd_addr;

  int tests = 0;
  int failures = 0;

  logic [31:0] mem_bus [256];
  logic [31:0] ref_mem [256];

  mem_wb_stage_if #(.DATA_W(DATA_W)) dmem ();

  mem_wb_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_result(ex_alu_result), .ex_read_data2(ex_read_data2), .ex_rd_addr(ex_rd_addr),
    .dmem(dmem), .stall(stall), .err(err),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data), .wb_rd_addr(wb_rd_addr)
  );

  always #5 clk = ~clk;

  assign dmem.rdata = mem_bus[dmem.addr[9:2]];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rw, input logic m2r, input logic rd, input logic wr,
                               input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rda);
    ex_reg_write  = rw;
    ex_mem_to_reg = m2r;
    ex_mem_read   = rd;
    ex_mem_write  = wr;
    ex_alu_result = alu;
    ex_read_data2 = wd;
    ex_rd_addr    = rda;
  endtask

  // One transaction from issue to retirement; memory answers after 'waits' stalled cycles.
  task automatic doTxn(input logic rw, input logic m2r, input logic rd, input logic wr,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rda,
                       input int waits);
    logic        is_mem, is_load, bus_we;
    logic [31:0] exp_data, bus_addr, bus_wdata;
    is_mem  = rd | wr;
    is_load = rd & ~wr;
    applyStimulus(rw, m2r, rd, wr, alu, wd, rda);
    dmem.ready = is_mem ? (waits == 0) : 1'($urandom);
    #1;
    checkOutput("req_issue", 32'(dmem.req), 32'(is_mem));
    checkOutput("stall_issue", 32'(stall), 32'(is_mem && waits > 0));
    if (is_mem) begin
      checkOutput("addr_issue", dmem.addr, alu);
      checkOutput("we_issue", 32'(dmem.we), 32'(wr));
      if (wr) checkOutput("wdata_issue", dmem.wdata, wd);
    end
    for (int k = 1; k <= waits; k++) begin
      tick();
      checkOutput("bubble", 32'(wb_reg_write), 32'd0);
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom, $urandom, 5'($urandom));
      dmem.ready = (k == waits);
      #1;
      checkOutput("req_wait", 32'(dmem.req), 32'd1);
      checkOutput("addr_stable", dmem.addr, alu);
      checkOutput("we_stable", 32'(dmem.we), 32'(wr));
      if (wr) checkOutput("wdata_stable", dmem.wdata, wd);
      checkOutput("stall_wait", 32'(stall), 32'(k != waits));
    end
    exp_data = is_load ? ref_mem[alu[9:2]] : 32'd0;
    if (is_mem && wr) ref_mem[alu[9:2]] = wd;
    bus_we    = dmem.req & dmem.ready & dmem.we;
    bus_addr  = dmem.addr;
    bus_wdata = dmem.wdata;
    tick();
    if (bus_we) mem_bus[bus_addr[9:2]] = bus_wdata;
    checkOutput("wb_reg_write", 32'(wb_reg_write), 32'(rw));
    checkOutput("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(m2r));
    checkOutput("wb_alu_result", wb_alu_result, alu);
    checkOutput("wb_rd_addr", 32'(wb_rd_addr), 32'(rda));
    checkOutput("wb_mem_data", wb_mem_data, exp_data);
    checkOutput("err_quiet", 32'(err), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      mem_bus[i] = d;
      ref_mem[i] = d;
    end
    mem_bus[8'h40] = 32'hDEADBEEF;
    ref_mem[8'h40] = 32'hDEADBEEF;

    // Reset holds everything quiet even with a load presented.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 5'd3);
    dmem.ready = 1'b0;
    #2;
    checkOutput("rst_req", 32'(dmem.req), 32'd0);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_reg_write", 32'(wb_reg_write), 32'd0);
    checkOutput("rst_alu_result", wb_alu_result, 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    tick();
    rst_n = 1'b1;

    doTxn(1'b1, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 0);
    doTxn(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd6, 0);
    doTxn(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'h55, 5'd0, 3);

    // Timeout: memory never answers.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd7);
    dmem.ready = 1'b0;
    #1;
    checkOutput("to_stall_issue", 32'(stall), 32'd1);
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      checkOutput("to_bubble", 32'(wb_reg_write), 32'd0);
      checkOutput("to_err_early", 32'(err), 32'd0);
      #1;
      checkOutput("to_req", 32'(dmem.req), 32'd1);
      checkOutput("to_stall", 32'(stall), 32'(k < TIMEOUT));
    end
    tick();
    checkOutput("to_err_pulse", 32'(err), 32'd1);
    checkOutput("to_retire_bubble", 32'(wb_reg_write), 32'd0);
    doTxn(1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFE, 32'h0, 5'd9, 0);

    // Reset while a load is stalled.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd9);
    dmem.ready = 1'b0;
    #1;
    checkOutput("mid_stall_issue", 32'(stall), 32'd1);
    tick();
    #1;
    checkOutput("mid_req_wait", 32'(dmem.req), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_req", 32'(dmem.req), 32'd0);
    checkOutput("mid_rst_stall", 32'(stall), 32'd0);
    checkOutput("mid_rst_reg_write", 32'(wb_reg_write), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    dmem.ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_req", 32'(dmem.req), 32'd0);
    checkOutput("post_rst_stall", 32'(stall), 32'd0);
    tick();
    checkOutput("post_rst_idle_req", 32'(dmem.req), 32'd0);
    checkOutput("post_rst_reg_write", 32'(wb_reg_write), 32'd0);

    // Back-to-back loads, one wait cycle each.
    doTxn(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd10, 1);
    doTxn(1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd11, 1);

    for (int n = 0; n < 30; n++) begin
      int op;
      int waits;
      logic [31:0] a;
      op    = int'($urandom_range(0, 3));
      waits = (op == 0) ? 0 : int'($urandom_range(0, 2));
      a     = (op == 0) ? $urandom : {22'd0, 8'($urandom), 2'b00};
      doTxn(1'($urandom), 1'($urandom), (op == 1 || op == 3), (op == 2 || op == 3),
            a, $urandom, 5'($urandom), waits);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
